// File: rtl/seg_pkg.sv
// Shared constants, engine state type and segment helpers for the 7-segment display controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } bcd_state_e;

  // Active-low segment pattern, bit order g..a
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int unsigned bcd_digits(input int unsigned w);
    return (3 * w + 9) / 10 + 1;
  endfunction

endpackage

// File: rtl/seg_disp_ctrl_if.sv
// Load/status bus between a datapath producer and the display controller.
interface seg_disp_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] iDATA;
  logic              iLOAD;
  logic              iMODE;
  logic              oBUSY;
  logic              oOVF;

  modport master (output iDATA, output iLOAD, output iMODE, input oBUSY, input oOVF);
  modport slave  (input iDATA, input iLOAD, input iMODE, output oBUSY, output oOVF);
endinterface

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, then one done cycle.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BCD_DIG = bcd_digits(DATA_W)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [DATA_W-1:0]    i_din,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*BCD_DIG-1:0] o_bcd
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  bcd_state_e           r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_bin, w_bin_nxt;
  logic [4*BCD_DIG-1:0] r_bcd, w_bcd_nxt, w_adj;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_adj       = r_bcd;
    for (int d = 0; d < int'(BCD_DIG); d++) begin
      if (r_bcd[4*d+:4] >= 4'd5) w_adj[4*d+:4] = r_bcd[4*d+:4] + 4'd3;
    end
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_bin_nxt   = i_din;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_bcd_nxt = {w_adj[4*BCD_DIG-2:0], r_bin[DATA_W-1]};
        w_bin_nxt = {r_bin[DATA_W-2:0], 1'b0};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = (r_state == StDone);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_disp_ctrl.sv
// N-digit 7-segment controller: hex or decimal display with LZ blanking, blink and overflow dashes.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG   = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  seg_disp_ctrl_if.slave         bus,
  input  logic                   iBLANK_LZ,
  input  logic [NUM_DIG-1:0]     iBLINK_MASK,
  output logic [7*NUM_DIG-1:0]   oHEX
);

  localparam int unsigned BCD_DIG = bcd_digits(DATA_W);
  localparam int unsigned DIG_W   = 4 * NUM_DIG;
  localparam int unsigned BCD_W   = 4 * BCD_DIG;
  localparam int unsigned HEX_EXT = (DATA_W > DIG_W) ? DATA_W : DIG_W;
  localparam int unsigned BCD_EXT = (BCD_W > DIG_W) ? BCD_W : DIG_W;
  localparam int unsigned PRE_W   = $clog2(BLINK_DIV);

  logic [DIG_W-1:0]     r_dig;
  logic                 r_ovf;
  logic                 r_valid;
  logic [PRE_W-1:0]     r_presc;
  logic                 r_phase;
  logic [7*NUM_DIG-1:0] r_hex;

  logic                 w_busy, w_done, w_accept, w_start;
  logic [BCD_W-1:0]     w_bcd;
  logic [HEX_EXT-1:0]   w_hex_ext;
  logic [BCD_EXT-1:0]   w_bcd_ext;
  logic                 w_hex_ovf, w_bcd_ovf;
  logic [7*NUM_DIG-1:0] w_hex_nxt;
  logic                 w_zero_above;
  logic [6:0]           w_seg;

  assign w_accept  = bus.iLOAD && !w_busy;
  assign w_start   = w_accept && bus.iMODE;
  assign w_hex_ext = HEX_EXT'(bus.iDATA);
  assign w_bcd_ext = BCD_EXT'(w_bcd);
  // Bits above the displayable digits must all be zero or the value is unrepresentable
  assign w_hex_ovf = |(w_hex_ext >> DIG_W);
  assign w_bcd_ovf = |(w_bcd_ext >> DIG_W);

  seg_bin2bcd #(
    .DATA_W  (DATA_W),
    .BCD_DIG (BCD_DIG)
  ) u_bin2bcd (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_start (w_start),
    .i_din   (bus.iDATA),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_dig   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_presc <= '0;
      r_phase <= 1'b0;
      r_hex   <= '1;
    end else begin
      if (w_accept && !bus.iMODE) begin
        r_dig   <= w_hex_ext[DIG_W-1:0];
        r_ovf   <= w_hex_ovf;
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_dig   <= w_bcd_ext[DIG_W-1:0];
        r_ovf   <= w_bcd_ovf;
        r_valid <= 1'b1;
      end
      if (r_presc == PRE_W'(BLINK_DIV - 1)) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_hex <= w_hex_nxt;
    end
  end

  // Walk from the top digit down so w_zero_above tracks "this digit and all above are zero"
  always_comb begin
    w_hex_nxt    = '1;
    w_zero_above = 1'b1;
    w_seg        = SEG_BLANK;
    for (int i = int'(NUM_DIG) - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above && (r_dig[4*i+:4] == 4'd0);
      if (!r_valid) begin
        w_seg = SEG_BLANK;
      end else if (r_ovf) begin
        w_seg = SEG_DASH;
      end else if (iBLANK_LZ && (i != 0) && w_zero_above) begin
        w_seg = SEG_BLANK;
      end else begin
        w_seg = hex2seg(r_dig[4*i+:4]);
      end
      if (r_phase && iBLINK_MASK[i]) w_seg = SEG_BLANK;
      w_hex_nxt[7*i+:7] = w_seg;
    end
  end

  assign oHEX      = r_hex;
  assign bus.oBUSY = w_busy;
  assign bus.oOVF  = r_ovf;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl: hex/decimal display, LZ blanking, overflow, blink, robustness.
module tb_seg_disp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        blank_lz;
  logic [7:0]  mask;
  logic [55:0] hex;

  int total = 0;
  int bad   = 0;
  int n;

  // Blink reference: prescaler wraps every 4 cycles, phase used for the registered output
  int   m_presc;
  logic m_phase;
  logic m_shown;

  seg_disp_ctrl_if #(.DATA_W(32)) bus ();

  seg_disp_ctrl #(
    .NUM_DIG   (8),
    .DATA_W    (32),
    .BLINK_DIV (4)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .bus         (bus),
    .iBLANK_LZ   (blank_lz),
    .iBLINK_MASK (mask),
    .oHEX        (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_presc <= 0;
      m_phase <= 1'b0;
      m_shown <= 1'b0;
    end else begin
      m_shown <= m_phase;
      if (m_presc == 3) begin
        m_presc <= 0;
        m_phase <= ~m_phase;
      end else begin
        m_presc <= m_presc + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] d, input logic m);
    bus.iDATA = d;
    bus.iMODE = m;
    bus.iLOAD = 1'b1;
    step();
    bus.iLOAD = 1'b0;
  endtask

  // Counts post-edge samples with busy high, starting from the sample after the accept edge
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.oBUSY === 1'b1 && cnt < 60) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    blank_lz  = 1'b0;
    mask      = 8'h00;
    bus.iDATA = '0;
    bus.iMODE = 1'b0;
    bus.iLOAD = 1'b0;

    // Reset
    repeat (3) step();
    chk("rst_hex", 64'(hex), 64'({8{7'h7F}}));
    chk("rst_busy", 64'(bus.oBUSY), 64'(1'b0));
    chk("rst_ovf", 64'(bus.oOVF), 64'(1'b0));
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_blank", 64'(hex), 64'({8{7'h7F}}));

    // Hex load: digit register written at accept edge, display one edge later
    load(32'h1234ABCD, 1'b0);
    chk("hex_busy", 64'(bus.oBUSY), 64'(1'b0));
    chk("hex_latency", 64'(hex[6:0]), 64'(7'h7F));
    step();
    chk("hex_value", 64'(hex),
        64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}));
    chk("hex_busy2", 64'(bus.oBUSY), 64'(1'b0));

    // Decimal 12345678
    load(32'd12345678, 1'b1);
    chk("dec_hold", 64'(hex[6:0]), 64'(7'h21));
    wait_idle(n);
    chk("dec_busy_len", 64'(n), 64'(33));
    chk("dec_commit_hold", 64'(hex[6:0]), 64'(7'h21));
    step();
    chk("dec_value", 64'(hex),
        64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    chk("dec_ovf", 64'(bus.oOVF), 64'(1'b0));

    // Decimal 42 with leading-zero blanking, then LZ turned off live
    blank_lz = 1'b1;
    load(32'd42, 1'b1);
    wait_idle(n);
    chk("dec42_busy_len", 64'(n), 64'(33));
    step();
    chk("lz_value", 64'(hex), 64'({{6{7'h7F}}, 7'h19, 7'h24}));
    blank_lz = 1'b0;
    step();
    chk("lz_off", 64'(hex), 64'({{6{7'h40}}, 7'h19, 7'h24}));

    // Overflow in decimal, cleared by a hex load of zero
    blank_lz = 1'b1;
    load(32'hFFFFFFFF, 1'b1);
    wait_idle(n);
    chk("ovf_flag", 64'(bus.oOVF), 64'(1'b1));
    step();
    chk("ovf_dash", 64'(hex), 64'({8{7'h3F}}));
    blank_lz = 1'b0;
    load(32'h0, 1'b0);
    chk("ovf_clear", 64'(bus.oOVF), 64'(1'b0));
    step();
    chk("zero_value", 64'(hex), 64'({8{7'h40}}));

    // Blink on digit 0 only
    load(32'h5, 1'b0);
    mask = 8'h01;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("blink_d0", 64'(hex[6:0]), 64'(m_shown ? 7'h7F : 7'h12));
      chk("blink_rest", 64'(hex[55:7]), 64'({7{7'h40}}));
    end
    mask = 8'h00;

    // Loads held through the whole conversion (incl. final busy cycle) are ignored
    bus.iDATA = 32'd99;
    bus.iMODE = 1'b1;
    bus.iLOAD = 1'b1;
    step();
    chk("rob_busy", 64'(bus.oBUSY), 64'(1'b1));
    bus.iDATA = 32'd7;
    bus.iMODE = 1'b0;
    wait_idle(n);
    bus.iLOAD = 1'b0;
    chk("rob_busy_len", 64'(n), 64'(33));
    step();
    chk("rob_value", 64'(hex), 64'({{6{7'h40}}, 7'h10, 7'h10}));
    chk("rob_idle", 64'(bus.oBUSY), 64'(1'b0));

    // Reset mid-conversion aborts without commit
    load(32'd12345678, 1'b1);
    repeat (10) step();
    chk("abort_busy_pre", 64'(bus.oBUSY), 64'(1'b1));
    rst_n = 1'b0;
    step();
    chk("abort_busy", 64'(bus.oBUSY), 64'(1'b0));
    chk("abort_hex", 64'(hex), 64'({8{7'h7F}}));
    rst_n = 1'b1;
    repeat (40) step();
    chk("abort_nocommit", 64'(hex), 64'({8{7'h7F}}));
    chk("abort_ovf", 64'(bus.oOVF), 64'(1'b0));
    chk("abort_idle", 64'(bus.oBUSY), 64'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
Parametrised N-digit 7-segment display controller for the DE2-115 HEX bank. It replaces one-decoder-per-nibble wiring with a single registered block. It accepts a binary word via a load strobe and shows it in hex, or in decimal using a sequential binary-to-BCD converter. It adds leading-zero blanking, per-digit blink and overflow indication, and sits between datapath modules (e.g. calculator cores) and the HEX pins.

Parameters:
NUM_DIG, 8, number of 7-segment digits driven (1..8)
DATA_W, 32, width of binary input word (4..32)
BLINK_DIV, 12500000, iCLK cycles per blink half-period (≥2; 50 MHz gives 2 Hz)

Ports:
iCLK  in  1  system clock (CLOCK_50)
iRST_N  in  1  synchronous active-low reset
iDATA  in  DATA_W  unsigned value to display
iLOAD  in  1  load strobe; accepted only when oBUSY=0
iMODE  in  1  0 = hex, 1 = decimal; sampled with iLOAD
iBLANK_LZ  in  1  1 = blank leading zeros; live
iBLINK_MASK  in  NUM_DIG  per-digit blink enable, bit i = digit i (digit 0 rightmost); live
oBUSY  out  1  decimal conversion in progress
oOVF  out  1  value does not fit NUM_DIG digits
oHEX  out  7*NUM_DIG  segments; oHEX[7i+6:7i] = digit i, bits g..a, active-low

Behaviour:
- Reset (iRST_N=0 at an iCLK edge): oHEX all ones (blank); oBUSY=0; oOVF=0; digit register cleared; show_valid=0; prescaler=0; blink phase=0.
- Reset mid-conversion aborts the conversion. No partial result is committed.
- Accept: iLOAD=1 and oBUSY=0 at edge k. iDATA and iMODE are captured. iLOAD while oBUSY=1 is ignored, including the final busy cycle.
- Hex mode: digit register = zero-extended iDATA nibbles, written at edge k.
  - Overflow when DATA_W > 4*NUM_DIG and the discarded bits are nonzero.
  - oHEX reflects the new value at edge k+1 (2-cycle latency from strobe).
- Decimal mode: the seg_bin2bcd double-dabble engine runs one shift/add-3 iteration per cycle.
  - oBUSY=1 from edge k for exactly DATA_W+1 cycles: DATA_W iterations plus 1 commit.
  - Digit register and oOVF are written at the commit edge, the same edge at which oBUSY falls. oHEX updates one edge later.
  - Overflow when any BCD digit at index ≥ NUM_DIG is nonzero.
  - The old display holds unchanged throughout conversion.
- Internal BCD width: BCD_DIG = (3*DATA_W+9)/10 + 1 digits.
- Overflow display: every digit shows a dash (7'h3F). oOVF=1 until the next commit.
- Leading-zero blanking (iBLANK_LZ=1): digits above the most-significant nonzero digit show blank (7'h7F). Digit 0 is never blanked. No effect when oOVF=1.
- Blink:
  - Prescaler counts 0..BLINK_DIV-1; at wrap, the phase toggles and the prescaler returns to 0. It free-runs from reset.
  - When phase=1, digits with the mask bit set are blanked. This applies on top of LZ blanking and dashes.
- Before the first commit after reset (show_valid=0), all digits are blank regardless of mask.
- oHEX is fully registered. Blanking and blink decisions are computed from current live inputs and registered each cycle, so live inputs take effect 1 cycle later.
- Encoding, active-low, g..a: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E blank=7F dash=3F.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK and SEG_DASH constants.
  - function hex2seg(4-bit) returning 7-bit active-low pattern.
  - function bcd_digits(DATA_W) computing BCD_DIG.
- Sub-module seg_bin2bcd (start, din, busy, done, bcd out): the sequential double-dabble engine.
- Top holds load control, digit register, blink prescaler and output register.

Test Plan:
1. Reset held 3 cycles → oHEX = all 1s, oBUSY=0, oOVF=0. Release with no load → stays blank.
2. Hex: iMODE=0, iDATA=32'h1234ABCD, 1-cycle iLOAD → 2 cycles later digit0=7'h21, digit4=7'h19, digit7=7'h79, oBUSY never high.
3. Decimal: iDATA=12345678, iMODE=1 → oBUSY high 33 cycles, then digits 7..0 show 1..8 (digit0=7'h00). Repeat with iDATA=42, iBLANK_LZ=1 → digits 7..2 = 7'h7F, digit1=7'h19, digit0=7'h24.
4. Overflow: decimal iDATA=32'hFFFFFFFF → after commit oOVF=1 and all digits 7'h3F. Next hex load of 0 → oOVF=0, digit0=7'h40.
5. Blink: BLINK_DIV=4, mask=8'h01, value 5 → digit0 alternates 7'h12 / 7'h7F every 4 cycles; other digits steady.
6. Robustness: iLOAD pulsed during conversion → ignored, result from first load. Assert iRST_N=0 mid-conversion → next edge oBUSY=0, oHEX blank, no commit.
